pipelined_alu: RTL and testbench
================================

// Module: pipelined_alu
// PURPOSE
//  Parametrised 2-stage pipelined ALU; successor to the 20-bit combinational ALU.
//  - Adds ready/valid handshakes on both sides, shifts, a compare-only op and a registered flag vector.
//  - Sits between operand fetch and writeback in the datapath; sustains one op per cycle under backpressure.
// PARAMETERS
//  WIDTH     20  operand/result width in bits (>=2)
//  SHAMT_W   $clog2(WIDTH)  shift-amount field width taken from in2 (derived, not overridden)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B (shift amount for SHL/SHR)
//  op_code    in   3      operation, see BEHAVIOUR
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  registered result
//  flags      out  5      {carry, zero, gt, lt, eq}, registered with result
// BEHAVIOUR
//  - Reset: out_valid=0, result=0, flags=0, stage-1 valid=0; in_ready=1 one cycle after release.
//  - Reset mid-operation discards every in-flight beat; nothing is replayed.
//  - Ops:
//    000 ADD  in1+in2
//    001 SUB  in1+~in2+1
//    010 AND
//    011 OR
//    100 XOR
//    101 SHL  logical left by in2
//    110 SHR  logical right by in2
//    111 CMP  result=0, flags only
//  - Shift: if in2 >= WIDTH then result=0, else shift by in2[SHAMT_W-1:0].
//  - Flags, all unsigned compares of in1 vs in2:
//    eq/lt/gt valid for every op.
//    carry = adder carry-out for ADD; no-borrow (in1>=in2) for SUB/CMP; 0 for all other ops.
//    zero = (result==0), evaluated on the final result.
//  - Handshake: beat accepted when in_valid&&in_ready; result consumed when out_valid&&out_ready.
//  - Pipeline: stage 1 registers operands+op; stage 2 computes and registers result+flags.
//  - Latency: accept in cycle N -> out_valid in cycle N+2 when not stalled.
//  - Stage advance: stage 2 loads when (!out_valid || out_ready); stage 1 loads when it is empty or advancing.
//  - in_ready = !s1_valid || s2_can_load. Purely combinational from state and out_ready.
//  - Full stall (out_ready=0, both stages valid): in_ready=0; result/flags hold stable; no beat lost or duplicated.
//  - Simultaneous accept and consume in one cycle is legal: throughput 1 op/cycle.
//  - Inputs are ignored when in_valid=0. result/flags change only on a stage-2 load.
// CONFIGURATION
//  ALU_SATURATE_EN defined:
//    ADD clamps to all-ones on carry-out; SUB clamps to 0 on borrow.
//    carry flag still reports the raw overflow.
//  ALU_SATURATE_EN undefined: ADD/SUB wrap modulo 2**WIDTH.
// STRUCTURE
//  - Package alu_pkg holds:
//    op_code localparams (OP_ADD..OP_CMP)
//    flag bit indices (FLAG_EQ, FLAG_LT, FLAG_GT, FLAG_ZERO, FLAG_CARRY)
//    flag vector width FLAGS_W=5
//  - Sub-module alu_core: purely combinational op/flag evaluation, parametrised by WIDTH, instantiated in stage 2.
//  - pipelined_alu owns only the pipeline registers and handshake logic.
// TESTING  (WIDTH=20 unless noted)
//  1. ADD 0xFFFFF+0x00001, out_ready=1 -> result 0x00000, carry=1, zero=1, out_valid 2 cycles after accept.
//  2. SUB 5-7 -> result 0xFFFFE, carry=0, lt=1; with ALU_SATURATE_EN -> result 0, carry=0.
//  3. SHL 0x00001 by 19 -> 0x80000; SHR 0x80000 by 20 -> 0 with zero=1.
//  4. Back-to-back 8 beats with out_ready=0 for 5 cycles mid-stream
//     -> in_ready low after 2 beats buffered, all 8 results in order, none lost or duplicated.
//  5. CMP 0x12345 vs 0x12345 -> result 0, eq=1, carry=1, zero=1; AND/OR/XOR spot values match model.
//  6. Assert rst_n=0 with both stages valid -> out_valid=0 immediately; after release no stale beat appears.
//  - Random op/operand stream vs reference model for WIDTH=8 and WIDTH=32, random in_valid/out_ready.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op codes, flag bit positions and flag vector width.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  // Flag vector layout is {carry, zero, gt, lt, eq}
  localparam int FLAG_EQ    = 0;
  localparam int FLAG_LT    = 1;
  localparam int FLAG_GT    = 2;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_CARRY = 4;
  localparam int FLAGS_W    = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational operation and flag evaluation for the pipelined ALU.
// Define ALU_SATURATE_EN to clamp ADD/SUB results instead of wrapping.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [2:0]         i_op,
  output logic [WIDTH-1:0]   o_result,
  output logic [FLAGS_W-1:0] o_flags
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH+1)'(WIDTH);

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic                 w_shOver;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [WIDTH-1:0]     w_res;
  logic                 w_carry;

  // Top bit of w_diff is the no-borrow indication (i_a >= i_b).
  assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff   = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shOver = ({1'b0, i_b} >= SHIFT_LIMIT);
  assign w_shamt  = i_b[SHAMT_W-1:0];

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
`ifdef ALU_SATURATE_EN
        if (w_sum[WIDTH]) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
`ifdef ALU_SATURATE_EN
        if (!w_diff[WIDTH]) w_res = '0;
`endif
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_SHL: w_res = w_shOver ? '0 : (i_a << w_shamt);
      OP_SHR: w_res = w_shOver ? '0 : (i_a >> w_shamt);
      OP_CMP: w_carry = w_diff[WIDTH];
      default: w_res = '0;
    endcase
  end

  assign o_result             = w_res;
  assign o_flags[FLAG_EQ]     = (i_a == i_b);
  assign o_flags[FLAG_LT]     = (i_a < i_b);
  assign o_flags[FLAG_GT]     = (i_a > i_b);
  assign o_flags[FLAG_ZERO]   = (w_res == '0);
  assign o_flags[FLAG_CARRY]  = w_carry;

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage ready/valid ALU: stage 1 holds operands, stage 2 holds result and flags.
// Saturating ADD/SUB is selected by defining ALU_SATURATE_EN (see alu_core).
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [2:0]         op_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags
);

  logic               r_s1Valid;
  logic [WIDTH-1:0]   r_s1A;
  logic [WIDTH-1:0]   r_s1B;
  logic [2:0]         r_s1Op;
  logic               r_outValid;
  logic [WIDTH-1:0]   r_result;
  logic [FLAGS_W-1:0] r_flags;

  logic               w_s2Load;
  logic               w_s1Load;
  logic [WIDTH-1:0]   w_coreResult;
  logic [FLAGS_W-1:0] w_coreFlags;

  // Stage 2 frees up when empty or being drained this cycle; stage 1 follows it.
  assign w_s2Load = !r_outValid || out_ready;
  assign w_s1Load = !r_s1Valid || w_s2Load;
  assign in_ready = w_s1Load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Op    <= '0;
    end else if (w_s1Load) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1A  <= in1;
        r_s1B  <= in2;
        r_s1Op <= op_code;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (r_s1A),
    .i_b      (r_s1B),
    .i_op     (r_s1Op),
    .o_result (w_coreResult),
    .o_flags  (w_coreFlags)
  );

  // Result and flags only move when a real beat enters stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_s2Load) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_result <= w_coreResult;
        r_flags  <= w_coreFlags;
      end
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed vectors on WIDTH=20 plus a random
// stream scored against a behavioural model on WIDTH=8/20/32 instances sharing one stimulus.
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic [2:0]  opCode;
  logic [31:0] in1;
  logic [31:0] in2;

  logic        rdy8, ov8;
  logic [7:0]  res8;
  logic [4:0]  fl8;
  logic        rdy20, ov20;
  logic [19:0] res20;
  logic [4:0]  fl20;
  logic        rdy32, ov32;
  logic [31:0] res32;
  logic [4:0]  fl32;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy8),
    .in1(in1[7:0]), .in2(in2[7:0]), .op_code(opCode),
    .out_valid(ov8), .out_ready(outReady), .result(res8), .flags(fl8)
  );

  pipelined_alu #(.WIDTH(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy20),
    .in1(in1[19:0]), .in2(in2[19:0]), .op_code(opCode),
    .out_valid(ov20), .out_ready(outReady), .result(res20), .flags(fl20)
  );

  pipelined_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy32),
    .in1(in1), .in2(in2), .op_code(opCode),
    .out_valid(ov32), .out_ready(outReady), .result(res32), .flags(fl32)
  );

  typedef struct {
    logic [2:0]  op;
    logic [19:0] a;
    logic [19:0] b;
    logic [19:0] res;
    logic [4:0]  fl;
    string       name;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          widths[3] = '{8, 20, 32};
  logic [68:0] expQ[3][$];
  logic        held[3];
  logic [63:0] heldRes[3];
  logic [4:0]  heldFl[3];
  logic        lastAccept;
  logic        sawStallLow;
  vec_t        vecs[12];

  // Reference: flags {carry, zero, gt, lt, eq} and result, packed as {flags, result}.
  function automatic logic [68:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] ain, input logic [31:0] bin);
    logic [63:0] mask, a, b, r;
    logic        c;
    mask = (64'd1 << w) - 64'd1;
    a = {32'h0, ain} & mask;
    b = {32'h0, bin} & mask;
    r = 64'h0;
    c = 1'b0;
    case (op)
      3'd0: begin
        c = (a + b) > mask;
        r = (a + b) & mask;
`ifdef ALU_SATURATE_EN
        if (c) r = mask;
`endif
      end
      3'd1: begin
        c = (a >= b);
        r = (a - b) & mask;
`ifdef ALU_SATURATE_EN
        if (!c) r = 64'h0;
`endif
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (b >= 64'(w)) ? 64'h0 : ((a << b[5:0]) & mask);
      3'd6: r = (b >= 64'(w)) ? 64'h0 : (a >> b[5:0]);
      default: begin
        c = (a >= b);
        r = 64'h0;
      end
    endcase
    return {c, (r == 64'h0), (a > b), (a < b), (a == b), r};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic getPort(input int k, output logic rdy, output logic ov,
                         output logic [63:0] res, output logic [4:0] fl);
    case (k)
      0:       begin rdy = rdy8;  ov = ov8;  res = {56'h0, res8};  fl = fl8;  end
      1:       begin rdy = rdy20; ov = ov20; res = {44'h0, res20}; fl = fl20; end
      default: begin rdy = rdy32; ov = ov32; res = {32'h0, res32}; fl = fl32; end
    endcase
  endtask

  // Scoreboard pass run between edges: predicts in_ready from occupancy, checks hold
  // stability under stall, pops on consume and pushes the model result on accept.
  task automatic monitor();
    logic        rdy, ov;
    logic [63:0] res;
    logic [4:0]  fl;
    logic [68:0] e;
    lastAccept = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        expQ[k].delete();
        held[k] = 1'b0;
      end
      return;
    end
    for (int k = 0; k < 3; k++) begin
      getPort(k, rdy, ov, res, fl);
      checkOutput($sformatf("in_ready w%0d", widths[k]), {63'h0, rdy},
                  {63'h0, !(expQ[k].size() == 2 && !outReady)});
      if (held[k]) begin
        checkOutput($sformatf("hold valid w%0d", widths[k]), {63'h0, ov}, 64'h1);
        checkOutput($sformatf("hold result w%0d", widths[k]), res, heldRes[k]);
        checkOutput($sformatf("hold flags w%0d", widths[k]), {59'h0, fl}, {59'h0, heldFl[k]});
      end
      if (ov && outReady) begin
        if (expQ[k].size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL spurious beat w%0d: got result 0x%0h, expected no beat", widths[k], res);
        end else begin
          e = expQ[k].pop_front();
          checkOutput($sformatf("result w%0d", widths[k]), res, e[63:0]);
          checkOutput($sformatf("flags w%0d", widths[k]), {59'h0, fl}, {59'h0, e[68:64]});
        end
      end
      held[k]    = ov && !outReady;
      heldRes[k] = res;
      heldFl[k]  = fl;
      if (inValid && rdy) begin
        expQ[k].push_back(model(widths[k], opCode, in1, in2));
        if (k == 1) lastAccept = 1'b1;
      end
      if (k == 1 && !rdy) sawStallLow = 1'b1;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [19:0] a, input logic [19:0] b);
    inValid = 1'b1;
    opCode  = op;
    in1     = {12'h0, a};
    in2     = {12'h0, b};
    stepCycle();
    inValid = 1'b0;
    in1     = $urandom;
    in2     = $urandom;
  endtask

  task automatic randomBeat();
    opCode = 3'($urandom_range(0, 7));
    in1    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    if (opCode == 3'd5 || opCode == 3'd6) in2 = $urandom_range(0, 40);
    else if ($urandom_range(0, 3) == 0)   in2 = in1;
    else                                  in2 = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;

    vecs[0]  = '{3'b000, 20'hFFFFF, 20'h00001, 20'h00000, 5'b11100, "add_carry"};
`ifdef ALU_SATURATE_EN
    vecs[0].res = 20'hFFFFF;
    vecs[0].fl  = 5'b10100;
    vecs[1]  = '{3'b001, 20'h00005, 20'h00007, 20'h00000, 5'b01010, "sub_borrow"};
`else
    vecs[1]  = '{3'b001, 20'h00005, 20'h00007, 20'hFFFFE, 5'b00010, "sub_borrow"};
`endif
    vecs[2]  = '{3'b101, 20'h00001, 20'h00013, 20'h80000, 5'b00010, "shl_19"};
    vecs[3]  = '{3'b110, 20'h80000, 20'h00014, 20'h00000, 5'b01100, "shr_20"};
    vecs[4]  = '{3'b111, 20'h12345, 20'h12345, 20'h00000, 5'b11001, "cmp_eq"};
    vecs[5]  = '{3'b010, 20'hF0F0F, 20'h0FF00, 20'h00F00, 5'b00100, "and"};
    vecs[6]  = '{3'b011, 20'hA0000, 20'h0000A, 20'hA000A, 5'b00100, "or"};
    vecs[7]  = '{3'b100, 20'h12345, 20'h12345, 20'h00000, 5'b01001, "xor_self"};
    vecs[8]  = '{3'b000, 20'h12345, 20'h11111, 20'h23456, 5'b00100, "add_plain"};
    vecs[9]  = '{3'b001, 20'h00010, 20'h00010, 20'h00000, 5'b11001, "sub_equal"};
    vecs[10] = '{3'b110, 20'h80000, 20'h00013, 20'h00001, 5'b00100, "shr_19"};
    vecs[11] = '{3'b101, 20'hFFFFF, 20'h00000, 20'hFFFFF, 5'b00100, "shl_0"};

    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    opCode   = 3'd0;
    in1      = 32'h0;
    in2      = 32'h0;
    for (int k = 0; k < 3; k++) held[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {63'h0, ov20}, 64'h0);
    checkOutput("reset result", {44'h0, res20}, 64'h0);
    checkOutput("reset flags", {59'h0, fl20}, 64'h0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("in_ready after reset", {63'h0, rdy20}, 64'h1);

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, " accepted"}, {63'h0, lastAccept}, 64'h1);
      checkOutput({vecs[i].name, " valid at N+1"}, {63'h0, ov20}, 64'h0);
      stepCycle();
      checkOutput({vecs[i].name, " valid at N+2"}, {63'h0, ov20}, 64'h1);
      checkOutput({vecs[i].name, " result"}, {44'h0, res20}, {44'h0, vecs[i].res});
      checkOutput({vecs[i].name, " flags"}, {59'h0, fl20}, {59'h0, vecs[i].fl});
      stepCycle();
    end

    $display("[TB] 8 beats with mid-stream stall");
    sent = 0;
    sawStallLow = 1'b0;
    randomBeat();
    for (int c = 0; c < 30; c++) begin
      outReady = !(c >= 3 && c < 8);
      inValid  = (sent < 8);
      stepCycle();
      if (lastAccept) begin
        sent++;
        randomBeat();
      end
    end
    inValid = 1'b0;
    checkOutput("stall beats sent", 64'(sent), 64'd8);
    checkOutput("stall in_ready dropped", {63'h0, sawStallLow}, 64'h1);
    checkOutput("stall pending drained", 64'(expQ[1].size()), 64'd0);

    $display("[TB] reset with both stages full");
    outReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomBeat();
      inValid = 1'b1;
      stepCycle();
    end
    inValid = 1'b0;
    checkOutput("full before reset", {63'h0, ov20}, 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset async out_valid w8", {63'h0, ov8}, 64'h0);
    checkOutput("reset async out_valid w20", {63'h0, ov20}, 64'h0);
    checkOutput("reset async out_valid w32", {63'h0, ov32}, 64'h0);
    checkOutput("reset async result", {44'h0, res20}, 64'h0);
    checkOutput("reset async flags", {59'h0, fl20}, 64'h0);
    stepCycle();
    rst_n = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("no stale beat", {63'h0, ov20}, 64'h0);
    end

    $display("[TB] random stream");
    for (int c = 0; c < 600; c++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      randomBeat();
      stepCycle();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (6) stepCycle();
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("random drained w%0d", widths[k]), 64'(expQ[k].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
